// File: rtl/sdrd_pkg.sv
// Shared types and helpers for the SDRD deserializer: FSM states, default
// resync code, the bus-read qualifier and a constant clog2.
package sdrd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] DEF_SYNC_CODE = 4'hF;

  function automatic logic qual(input logic sser_n, input logic ba13,
                                input logic ba12, input logic br_w);
    return ~sser_n & ~ba13 & ba12 & br_w;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sdrd_fifo.sv
// Synchronous FIFO with simultaneous push/pop. Head word and valid are
// registered so the consumer sees flop outputs only.
module sdrd_fifo
  import sdrd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_push,
  input  logic [WIDTH-1:0]              i_push_data,
  input  logic                          i_pop,
  output logic [WIDTH-1:0]              o_data,
  output logic                          o_valid,
  output logic [clog2(DEPTH+1)-1:0]     o_count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_head;
  logic             r_valid;

  logic             w_full;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [AW-1:0]    w_rd_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign w_full      = (r_count == CW'(DEPTH));
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push_ok   = i_push & (~w_full | (i_pop & r_valid));
  assign w_pop_ok    = i_pop & r_valid;
  assign w_rd_nxt    = r_rd_ptr + AW'(w_pop_ok);
  assign w_count_nxt = r_count + CW'(w_push_ok) - CW'(w_pop_ok);

  // Next head word, forwarding the incoming word when it lands at the new read slot
  always_comb begin
    w_head_nxt = r_mem[w_rd_nxt];
    if (w_push_ok && (r_wr_ptr == w_rd_nxt)) begin
      w_head_nxt = i_push_data;
    end else begin
      w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  // Storage array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers, occupancy and registered head/valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push_ok);
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
      r_head   <= w_head_nxt;
      r_valid  <= (w_count_nxt != '0);
    end
  end

  assign o_data  = r_head;
  assign o_valid = r_valid;
  assign o_count = r_count;

endmodule

// File: rtl/sdrd_deserializer.sv
// Deserializes SDRD bits sampled on qualified bus reads into words, queues
// them in a small FIFO and reports lost data through sticky flags.
module sdrd_deserializer
  import sdrd_pkg::*;
#(
  parameter int         WORD_BITS  = 8,
  parameter int         SAMPLE_DLY = 2,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] SYNC_CODE  = DEF_SYNC_CODE
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_sser_n,
  input  logic                              i_ba13,
  input  logic                              i_ba12,
  input  logic [3:0]                        i_ba_hi,
  input  logic                              i_br_w,
  input  logic                              i_sdrd,
  output logic [WORD_BITS-1:0]              o_out_data,
  output logic                              o_out_valid,
  input  logic                              i_out_ready,
  output logic [clog2(WORD_BITS+1)-1:0]     o_bit_cnt,
  output logic                              o_ovf,
  output logic                              o_abort,
  input  logic                              i_clr_flags
);

  localparam int         BCW      = clog2(WORD_BITS + 1);
  localparam int         FCW      = clog2(FIFO_DEPTH + 1);
  localparam logic [3:0] DLY_LOAD = 4'(SAMPLE_DLY - 1);
  // Idle levels: strobe deasserted, SDRD pulled high.
  localparam logic [8:0] SYNC_RST = 9'b1_0_0_0_1_0000;

  logic [8:0]           r_sync1;
  logic [8:0]           r_sync2;
  logic                 r_qual_d;
  state_t               r_state;
  logic [3:0]           r_dly;
  logic                 r_bit;
  logic [WORD_BITS-1:0] r_sreg;
  logic [BCW-1:0]       r_bit_cnt;
  logic                 r_ovf;
  logic                 r_abort;

  logic                 w_sser_s;
  logic                 w_ba13_s;
  logic                 w_ba12_s;
  logic                 w_br_w_s;
  logic                 w_sdrd_s;
  logic [3:0]           w_ba_hi_s;
  logic                 w_qual;
  logic                 w_start;
  state_t               w_state_nxt;
  logic [3:0]           w_dly_nxt;
  logic                 w_bit_nxt;
  logic [WORD_BITS-1:0] w_sreg_nxt;
  logic [BCW-1:0]       w_cnt_nxt;
  logic                 w_push;
  logic                 w_abort_set;
  logic                 w_pop;
  logic                 w_ovf_set;
  logic [FCW-1:0]       w_fifo_count;

  // All bus inputs share one two-stage synchronizer so they stay cycle-aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= SYNC_RST;
      r_sync2 <= SYNC_RST;
    end else begin
      r_sync1 <= {i_sser_n, i_ba13, i_ba12, i_br_w, i_sdrd, i_ba_hi};
      r_sync2 <= r_sync1;
    end
  end

  assign {w_sser_s, w_ba13_s, w_ba12_s, w_br_w_s, w_sdrd_s, w_ba_hi_s} = r_sync2;
  assign w_qual  = qual(w_sser_s, w_ba13_s, w_ba12_s, w_br_w_s);
  assign w_start = w_qual & ~r_qual_d;

  // Next-state and datapath decode
  always_comb begin
    w_state_nxt = r_state;
    w_dly_nxt   = r_dly;
    w_bit_nxt   = r_bit;
    w_sreg_nxt  = r_sreg;
    w_cnt_nxt   = r_bit_cnt;
    w_push      = 1'b0;
    w_abort_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          if (w_ba_hi_s == SYNC_CODE) begin
            w_cnt_nxt   = '0;
            w_sreg_nxt  = '0;
            w_state_nxt = ST_HOLD;
          end else begin
            w_dly_nxt   = DLY_LOAD;
            w_state_nxt = ST_WAIT;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // Capture SDRD here so the bit is taken exactly SAMPLE_DLY cycles after start.
        if ((r_dly == 4'd0) && w_qual) begin
          w_bit_nxt   = w_sdrd_s;
          w_state_nxt = ST_SAMPLE;
        end else if (!w_qual) begin
          w_abort_set = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_dly_nxt   = r_dly - 4'd1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_SAMPLE: begin
        w_sreg_nxt = {r_sreg[WORD_BITS-2:0], r_bit};
        if (r_bit_cnt == BCW'(WORD_BITS - 1)) begin
          w_push    = 1'b1;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_bit_cnt + BCW'(1);
        end
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (!w_qual) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state and access-edge tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_qual_d <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_qual_d <= w_qual;
    end
  end

  // Delay counter, sampled bit, shift register and bit count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dly     <= 4'd0;
      r_bit     <= 1'b0;
      r_sreg    <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_dly     <= w_dly_nxt;
      r_bit     <= w_bit_nxt;
      r_sreg    <= w_sreg_nxt;
      r_bit_cnt <= w_cnt_nxt;
    end
  end

  assign w_pop     = o_out_valid & i_out_ready;
  assign w_ovf_set = w_push & (w_fifo_count == FCW'(FIFO_DEPTH)) & ~w_pop;

  // Sticky flags: a set in the same cycle as a clear survives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf   <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_ovf   <= w_ovf_set | (r_ovf & ~i_clr_flags);
      r_abort <= w_abort_set | (r_abort & ~i_clr_flags);
    end
  end

  sdrd_fifo #(
    .WIDTH (WORD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_sreg_nxt),
    .i_pop       (w_pop),
    .o_data      (o_out_data),
    .o_valid     (o_out_valid),
    .o_count     (w_fifo_count)
  );

  assign o_bit_cnt = r_bit_cnt;
  assign o_ovf     = r_ovf;
  assign o_abort   = r_abort;

endmodule

// File: tb/tb_sdrd_deserializer.sv
// Scoreboard bench for sdrd_deserializer: a bit-level model pushes expected
// words into a queue that is compared as the DUT FIFO drains.
module tb_sdrd_deserializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sser_n, ba13, ba12, br_w, sdrd, out_ready, clr_flags;
  logic [3:0] ba_hi;
  logic [7:0] out_data;
  logic       out_valid;
  logic [3:0] bit_cnt;
  logic       ovf, abort_f;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_word = 8'h00;
  int         m_cnt = 0;

  always #5 clk = ~clk;

  sdrd_deserializer #(
    .WORD_BITS (8),
    .SAMPLE_DLY(2),
    .FIFO_DEPTH(4),
    .SYNC_CODE (4'hF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_sser_n   (sser_n),
    .i_ba13     (ba13),
    .i_ba12     (ba12),
    .i_ba_hi    (ba_hi),
    .i_br_w     (br_w),
    .i_sdrd     (sdrd),
    .o_out_data (out_data),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_bit_cnt  (bit_cnt),
    .o_ovf      (ovf),
    .o_abort    (abort_f),
    .i_clr_flags(clr_flags)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    sser_n = 1'b1; ba13 = 1'b0; ba12 = 1'b1; br_w = 1'b1; ba_hi = 4'h0; sdrd = 1'b1;
  endtask

  // Model of one data bit; words beyond four are dropped as the DUT FIFO would.
  task automatic model_bit(input logic b);
    m_word = {m_word[6:0], b};
    m_cnt  = m_cnt + 1;
    if (m_cnt == 8) begin
      m_cnt = 0;
      if (exp_q.size() < 4) exp_q.push_back(m_word);
    end
  endtask

  task automatic send_read(input logic b, input logic [3:0] hi, input logic clr);
    sser_n = 1'b0; ba13 = 1'b0; ba12 = 1'b1; br_w = 1'b1; ba_hi = hi; sdrd = b;
    step(5);
    if (clr) clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    bus_idle();
    step(4);
    if (hi != 4'hF) model_bit(b);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_read(w[i], 4'h0, 1'b0);
  endtask

  task automatic drain();
    int n_exp, n_got, guard;
    logic [7:0] w;
    n_exp = exp_q.size(); n_got = 0; guard = 0;
    out_ready = 1'b1;
    while (out_valid === 1'b1 && guard < 16) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL drain_extra: got word %h, expected none", out_data);
      end else begin
        w = exp_q.pop_front();
        if (out_data !== w) begin
          errors++;
          $display("FAIL drain_data: got %h expected %h", out_data, w);
        end
      end
      n_got++; guard++;
      step(1);
    end
    out_ready = 1'b0;
    checks++;
    if (n_got != n_exp) begin
      errors++;
      $display("FAIL drain_count: got %0d words expected %0d", n_got, n_exp);
    end
  endtask

  task automatic test_reset();
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    if (out_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h expected 00", out_data); end
    if (bit_cnt !== 4'd0) begin errors++; $display("FAIL rst_bitcnt: got %0d expected 0", bit_cnt); end
    if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", ovf); end
    if (abort_f !== 1'b0) begin errors++; $display("FAIL rst_abort: got %b expected 0", abort_f); end
  endtask

  task automatic test_basic_word();
    logic [7:0] w;
    w = 8'hA5;
    for (int i = 7; i >= 1; i--) send_read(w[i], 4'h0, 1'b0);
    checks++;
    if (bit_cnt !== 4'd7) begin errors++; $display("FAIL basic_bitcnt7: got %0d expected 7", bit_cnt); end
    send_read(w[0], 4'h0, 1'b0);
    checks += 3;
    if (bit_cnt !== 4'd0) begin errors++; $display("FAIL basic_bitcnt0: got %0d expected 0", bit_cnt); end
    if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
    if (out_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", out_data); end
    drain();
  endtask

  // SDRD differs from the wanted bit one cycle before and after the sample point.
  task automatic test_sample_timing();
    logic [7:0] pat;
    pat = 8'h69;
    for (int i = 7; i >= 0; i--) begin
      sser_n = 1'b0; ba13 = 1'b0; ba12 = 1'b1; br_w = 1'b1; ba_hi = 4'h0;
      sdrd = ~pat[i];
      step(2);
      sdrd = pat[i];
      step(1);
      sdrd = ~pat[i];
      step(3);
      bus_idle();
      step(4);
      model_bit(pat[i]);
    end
    drain();
  endtask

  task automatic test_resync();
    send_read(1'b1, 4'h0, 1'b0);
    send_read(1'b0, 4'h0, 1'b0);
    send_read(1'b1, 4'h0, 1'b0);
    checks++;
    if (bit_cnt !== 4'd3) begin errors++; $display("FAIL resync_pre: got %0d expected 3", bit_cnt); end
    send_read(1'b0, 4'hF, 1'b0);
    m_cnt = 0; m_word = 8'h00;
    checks++;
    if (bit_cnt !== 4'd0) begin errors++; $display("FAIL resync_clr: got %0d expected 0", bit_cnt); end
    send_word(8'h3C);
    drain();
  endtask

  task automatic test_overflow();
    logic [7:0] w;
    send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44); send_word(8'h55);
    checks += 2;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", ovf); end
    if (bit_cnt !== 4'd0) begin errors++; $display("FAIL ovf_bitcnt: got %0d expected 0", bit_cnt); end
    drain();
    clr_flags = 1'b1; step(1); clr_flags = 1'b0; step(1);
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b expected 0", ovf); end
    // Clear pulse coincides with the dropping push: the new overflow must stick.
    send_word(8'h66); send_word(8'h77); send_word(8'h88); send_word(8'h99);
    w = 8'hE1;
    for (int i = 7; i >= 1; i--) send_read(w[i], 4'h0, 1'b0);
    send_read(w[0], 4'h0, 1'b1);
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_same_cycle: got %b expected 1", ovf); end
    drain();
    clr_flags = 1'b1; step(1); clr_flags = 1'b0; step(1);
  endtask

  task automatic test_abort();
    send_read(1'b1, 4'h0, 1'b0);
    send_read(1'b1, 4'h0, 1'b0);
    sser_n = 1'b0; ba13 = 1'b0; ba12 = 1'b1; br_w = 1'b1; sdrd = 1'b0;
    step(2);
    bus_idle();
    step(6);
    checks += 3;
    if (abort_f !== 1'b1) begin errors++; $display("FAIL abort_set: got %b expected 1", abort_f); end
    if (bit_cnt !== 4'd2) begin errors++; $display("FAIL abort_bitcnt: got %0d expected 2", bit_cnt); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_nopush: got %b expected 0", out_valid); end
    clr_flags = 1'b1; step(1); clr_flags = 1'b0; step(1);
    checks++;
    if (abort_f !== 1'b0) begin errors++; $display("FAIL abort_clr: got %b expected 0", abort_f); end
    for (int i = 0; i < 6; i++) send_read(i[0], 4'h0, 1'b0);
    drain();
  endtask

  task automatic test_ignored();
    for (int k = 0; k < 3; k++) begin
      sser_n = (k == 2); ba13 = (k == 1); ba12 = 1'b1; br_w = (k != 0); ba_hi = 4'h0; sdrd = 1'b0;
      step(6);
      bus_idle();
      step(4);
    end
    checks += 3;
    if (bit_cnt !== 4'd0) begin errors++; $display("FAIL ignored_bitcnt: got %0d expected 0", bit_cnt); end
    if (abort_f !== 1'b0) begin errors++; $display("FAIL ignored_abort: got %b expected 0", abort_f); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL ignored_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_in_wait();
    send_word(8'h5A);
    for (int i = 0; i < 5; i++) send_read(1'b1, 4'h0, 1'b0);
    sser_n = 1'b0; ba13 = 1'b0; ba12 = 1'b1; br_w = 1'b1; sdrd = 1'b0;
    step(3);
    rst_n = 1'b0;
    #1;
    test_reset();
    exp_q.delete(); m_cnt = 0; m_word = 8'h00;
    bus_idle();
    step(2);
    rst_n = 1'b1;
    step(2);
    send_word(8'hC3);
    drain();
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
    bus_idle();
    step(3);
    rst_n = 1'b1;
    step(2);
    test_reset();
    test_basic_word();
    test_sample_timing();
    test_resync();
    test_overflow();
    test_abort();
    test_ignored();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
